// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: vertical motion controller for the dino sprite.
// Converts a raw jump button into a per-frame ballistic trajectory and
// drives the sprite screen position. Motion only advances on frame_tick.
//
// state       | meaning
// ------------+----------------------------------------------
// ST_GROUNDED | on the ground, height = 0, vel = 0
// ST_AIRBORNE | in flight, height/vel integrate per frame
module dino_jump_ctrl #(
  parameter logic [9:0]  X_POS    = 10'd100,
  parameter logic [9:0]  GROUND_Y = 10'd400,
  parameter int unsigned JUMP_V   = 12,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned MAX_FALL = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       jump_btn,
  input  logic       freeze,
  output logic [9:0] x_desired,
  output logic [9:0] y_desired,
  output logic       airborne,
  output logic       landed
);

  typedef enum logic {
    ST_GROUNDED = 1'b0,
    ST_AIRBORNE = 1'b1
  } state_t;

  localparam logic signed [7:0] LP_JUMP_V  = 8'(JUMP_V);
  localparam logic signed [8:0] LP_GRAVITY = 9'(GRAVITY);
  localparam logic signed [8:0] LP_MIN_VEL = -(9'(MAX_FALL));

  state_t             r_state;
  state_t             w_state_nxt;
  logic        [9:0]  r_height;
  logic        [9:0]  w_height_nxt;
  logic signed [7:0]  r_vel;
  logic signed [7:0]  w_vel_nxt;
  logic               r_landed;
  logic               w_landed_nxt;
  logic        [9:0]  r_y;

  logic               r_sync1;
  logic               r_sync2;
  logic               r_sync_d;
  logic               r_pending;
  logic               w_jump_edge;
  logic               w_tick;

  logic signed [10:0] w_sum;
  logic signed [8:0]  w_vel_dec;
  logic signed [8:0]  w_vel_fall;

  assign w_jump_edge = r_sync2 & ~r_sync_d;
  assign w_tick      = frame_tick & ~freeze;

  // height + vel in 11-bit signed so a downward step below ground is visible
  assign w_sum      = $signed({1'b0, r_height}) + $signed({{3{r_vel[7]}}, r_vel});
  assign w_vel_dec  = $signed({r_vel[7], r_vel}) - LP_GRAVITY;
  assign w_vel_fall = (w_vel_dec < LP_MIN_VEL) ? LP_MIN_VEL : w_vel_dec;

  // Button synchronizer and rising-edge delay register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= jump_btn;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // Jump request flag: a tick consumes/discards it, but an edge arriving on
  // the tick cycle itself survives for the following tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (freeze) begin
      r_pending <= 1'b0;
    end else if (frame_tick) begin
      r_pending <= w_jump_edge;
    end else if (w_jump_edge) begin
      r_pending <= 1'b1;
    end
  end

  // State register with motion datapath and registered screen row
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_GROUNDED;
      r_height <= '0;
      r_vel    <= '0;
      r_landed <= 1'b0;
      r_y      <= GROUND_Y;
    end else begin
      r_state  <= w_state_nxt;
      r_height <= w_height_nxt;
      r_vel    <= w_vel_nxt;
      r_landed <= w_landed_nxt;
      r_y      <= GROUND_Y - r_height;
    end
  end

  // Next-state and motion update, evaluated only on an unfrozen tick
  always_comb begin
    w_state_nxt  = r_state;
    w_height_nxt = r_height;
    w_vel_nxt    = r_vel;
    w_landed_nxt = 1'b0;
    if (w_tick) begin
      if (r_state == ST_GROUNDED) begin
        if (r_pending) begin
          w_state_nxt  = ST_AIRBORNE;
          w_vel_nxt    = LP_JUMP_V;
          w_height_nxt = '0;
        end
      end else begin
        if (w_sum <= 11'sd0) begin
          w_state_nxt  = ST_GROUNDED;
          w_height_nxt = '0;
          w_vel_nxt    = '0;
          w_landed_nxt = 1'b1;
        end else begin
          w_height_nxt = w_sum[9:0];
          w_vel_nxt    = w_vel_fall[7:0];
        end
      end
    end
  end

  // Outputs decoded from state and registers
  always_comb begin
    airborne  = (r_state == ST_AIRBORNE);
    landed    = r_landed;
    x_desired = X_POS;
    y_desired = r_y;
  end

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl: a default-parameter instance driven by a
// vector table, plus a JUMP_V=20 / MAX_FALL=5 instance for clamp and reset.
module tb_dino_jump_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       jump_btn = 1'b0;
  logic       freeze = 1'b0;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_air, a_land, b_air, b_land;

  always #5 clk = ~clk;

  dino_jump_ctrl u_dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .jump_btn(jump_btn),
    .freeze(freeze), .x_desired(a_x), .y_desired(a_y), .airborne(a_air),
    .landed(a_land)
  );

  dino_jump_ctrl #(.JUMP_V(20), .MAX_FALL(5)) u_dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .jump_btn(jump_btn),
    .freeze(freeze), .x_desired(b_x), .y_desired(b_y), .airborne(b_air),
    .landed(b_land)
  );

  typedef struct {
    logic btn;
    logic frz;
    int   exp_y;
    logic exp_air;
    logic exp_land;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int s_a_y, s_a_air, s_a_land1, s_a_land2;
  int s_b_y, s_b_air, s_b_land1, s_b_land2;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic btn, input logic frz, input int y,
                     input logic air, input logic land);
    vec_t v;
    v.btn = btn; v.frz = frz; v.exp_y = y; v.exp_air = air; v.exp_land = land;
    vecs.push_back(v);
  endtask

  task automatic press();
    jump_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 jump_btn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // One-cycle tick; airborne/landed sampled at T+1, y_desired at T+2
  task automatic tick();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    s_a_air = int'(a_air); s_a_land1 = int'(a_land);
    s_b_air = int'(b_air); s_b_land1 = int'(b_land);
    @(posedge clk);
    #1;
    s_a_y = int'(a_y); s_a_land2 = int'(a_land);
    s_b_y = int'(b_y); s_b_land2 = int'(b_land);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int hts[24] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
                    78, 77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12};
    int h;
    int prev_y;
    int seen;

    for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 400, 1'b0, 1'b0);
    add(1'b1, 1'b0, 400, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) add(i == 11, 1'b0, 400 - hts[i], 1'b1, 1'b0);
    add(1'b1, 1'b0, 400, 1'b0, 1'b1);
    add(1'b0, 1'b0, 400, 1'b0, 1'b0);
    add(1'b0, 1'b0, 400, 1'b0, 1'b0);
    add(1'b1, 1'b0, 400, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b0, 1'b0, 400 - hts[i], 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b1, 1'b1, 343, 1'b1, 1'b0);
    add(1'b0, 1'b0, 337, 1'b1, 1'b0);
    for (int i = 7; i < 24; i++) add(1'b0, 1'b0, 400 - hts[i], 1'b1, 1'b0);
    add(1'b0, 1'b0, 400, 1'b0, 1'b1);
    add(1'b1, 1'b1, 400, 1'b0, 1'b0);
    add(1'b0, 1'b0, 400, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_y", int'(a_y), 400);
    chk("reset_x", int'(a_x), 100);
    chk("reset_air", int'(a_air), 0);
    chk("reset_landed", int'(a_land), 0);
    chk("reset_b_x", int'(b_x), 100);

    foreach (vecs[i]) begin
      freeze = vecs[i].frz;
      if (vecs[i].btn) press();
      tick();
      chk($sformatf("vec%0d_y", i), s_a_y, vecs[i].exp_y);
      chk($sformatf("vec%0d_air", i), s_a_air, int'(vecs[i].exp_air));
      chk($sformatf("vec%0d_landed", i), s_a_land1, int'(vecs[i].exp_land));
      chk($sformatf("vec%0d_landed_drop", i), s_a_land2, 0);
    end
    freeze = 1'b0;

    // edge and grounded tick sampled on the same clock edge
    @(posedge clk);
    #1 jump_btn = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    chk("collide_no_launch", int'(a_air), 0);
    repeat (4) @(posedge clk);
    #1 jump_btn = 1'b0;
    tick();
    chk("collide_next_launch", s_a_air, 1);
    chk("collide_next_y", s_a_y, 400);

    // clamp instance: full jump with MAX_FALL = 5
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    press();
    tick();
    chk("b_launch_air", s_b_air, 1);
    chk("b_launch_y", s_b_y, 400);
    prev_y = 400;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k <= 64) begin
        h = (k <= 25) ? (20 * k - (k * (k - 1)) / 2) : (200 - 5 * (k - 25));
        chk($sformatf("b_tick%0d_y", k), s_b_y, 400 - h);
        chk($sformatf("b_tick%0d_air", k), s_b_air, 1);
      end else begin
        chk("b_land_y", s_b_y, 400);
        chk("b_land_air", s_b_air, 0);
        chk("b_land_pulse", s_b_land1, 1);
        chk("b_land_drop", s_b_land2, 0);
      end
      if (k >= 21) chk($sformatf("b_tick%0d_step_le5", k), int'((s_b_y - prev_y) <= 5), 1);
      prev_y = s_b_y;
    end

    // reset during descent
    press();
    tick();
    for (int k = 1; k <= 30; k++) tick();
    chk("b_pre_reset_y", s_b_y, 225);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("b_reset_y", int'(b_y), 400);
    chk("b_reset_air", int'(b_air), 0);
    chk("b_reset_landed", int'(b_land), 0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (b_land) seen++;
    end
    chk("b_no_landed_after_reset", seen, 0);
    tick();
    chk("b_post_reset_tick_y", s_b_y, 400);
    chk("b_post_reset_tick_air", s_b_air, 0);
    chk("b_post_reset_tick_landed", s_b_land1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
